// File: rtl/xalu_muldiv.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div with fixed latency, mthi/mtlo in one cycle.
// Optional multiply-accumulate (madd/maddu) is built only when XALU_MADD_EN is defined.
module xalu_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    op_e         op_q, op_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    // Arithmetic works only on the latched operands, so A/B may change during RUN.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    logic [31:0] a_mag, b_mag, b_divisor;
    logic [31:0] uq, ur, sq_mag, sr_mag, sq, sr;
    logic        div_by_zero;
    assign div_by_zero = (b_q == 32'd0);
    assign a_mag       = a_q[31] ? (32'd0 - a_q) : a_q;
    assign b_mag       = b_q[31] ? (32'd0 - b_q) : b_q;
    assign b_divisor   = div_by_zero ? 32'd1 : b_q;
    assign uq          = a_q / b_divisor;
    assign ur          = a_q % b_divisor;
    assign sq_mag      = a_mag / (div_by_zero ? 32'd1 : b_mag);
    assign sr_mag      = a_mag % (div_by_zero ? 32'd1 : b_mag);
    assign sq          = (a_q[31] ^ b_q[31]) ? (32'd0 - sq_mag) : sq_mag;
    assign sr          = a_q[31] ? (32'd0 - sr_mag) : sr_mag;

`ifdef XALU_MADD_EN
    logic [63:0] acc_s, acc_u;
    assign acc_s = {hi_q, lo_q} + prod_s;
    assign acc_u = {hi_q, lo_q} + prod_u;
`endif

    // NOTE: every signal is given its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op_e'(op))
                        OP_MULT, OP_MULTU: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op_e'(op);
                            cnt_d   = 4'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op_e'(op);
                            cnt_d   = 4'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
`ifdef XALU_MADD_EN
                        OP_MADD, OP_MADDU: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op_e'(op);
                            cnt_d   = 4'(MULT_CYCLES);
                            state_d = RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Requests arriving while running are dropped; the hazard unit should prevent them.
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_d = IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV: begin
                            if (!div_by_zero) begin
                                lo_d = sq;
                                hi_d = sr;
                            end
                        end
                        OP_DIVU: begin
                            if (!div_by_zero) begin
                                lo_d = uq;
                                hi_d = ur;
                            end
                        end
`ifdef XALU_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = acc_s;
                        OP_MADDU: {hi_d, lo_d} = acc_u;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= OP_MULT;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign busy = (state == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_xalu_muldiv.sv
// Directed self-checking bench for xalu_muldiv; define XALU_MADD_EN to exercise madd.
module tb_xalu_muldiv;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int failures = 0;

    xalu_muldiv #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; afterwards the operand buses carry junk to prove they are latched.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        step();
        start = 1'b0;
        op    = 3'd0;
        A     = 32'hDEADBEEF;
        B     = 32'hDEADBEEF;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL reset: busy=%b HI=%h LO=%h, want busy=0 HI=0 LO=0", busy, HI, LO);
        end
        reset = 1'b0;
    endtask

    task automatic test_arith();
        vec_t v[7];
        int   n;
        v[0] = '{"mult_neg",   OP_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        v[1] = '{"multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        v[2] = '{"mult_2p32",  OP_MULT,  32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
        v[3] = '{"div_neg7_2", OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        v[4] = '{"div_7_neg2", OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        v[5] = '{"div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        v[6] = '{"divu_100_7", OP_DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14};
        // Issued back to back: each request goes in on the first idle cycle.
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b);
            wait_idle(n);
            checks++;
            if (n !== v[i].cycles) begin
                failures++;
                $display("FAIL %s busy_cycles: got %0d want %0d", v[i].name, n, v[i].cycles);
            end
            checks++;
            if (HI !== v[i].hi) begin
                failures++;
                $display("FAIL %s HI: got %h want %h", v[i].name, HI, v[i].hi);
            end
            checks++;
            if (LO !== v[i].lo) begin
                failures++;
                $display("FAIL %s LO: got %h want %h", v[i].name, LO, v[i].lo);
            end
        end
    endtask

    task automatic test_divzero();
        int n;
        issue(OP_MTHI, 32'h12345678, 32'd0);
        checks++;
        if (HI !== 32'h12345678 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi: HI=%h busy=%b want HI=12345678 busy=0", HI, busy);
        end
        issue(OP_MTLO, 32'h9ABCDEF0, 32'd0);
        checks++;
        if (LO !== 32'h9ABCDEF0 || HI !== 32'h12345678 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mtlo: HI=%h LO=%h busy=%b want 12345678/9abcdef0/0", HI, LO, busy);
        end
        issue(OP_DIVU, 32'd55, 32'd0);
        wait_idle(n);
        checks++;
        if (n !== 10) begin
            failures++;
            $display("FAIL divzero busy_cycles: got %0d want 10", n);
        end
        checks++;
        if (HI !== 32'h12345678 || LO !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL divzero HI/LO: got %h/%h want 12345678/9abcdef0", HI, LO);
        end
    endtask

    task automatic test_ignore_start();
        int n;
        issue(OP_DIVU, 32'd100, 32'd7);
        step();
        step();
        // Busy cycle 3: a new request must be dropped.
        start = 1'b1;
        op    = OP_MTLO;
        A     = 32'd5;
        step();
        start = 1'b0;
        wait_idle(n);
        checks++;
        if (n !== 7) begin
            failures++;
            $display("FAIL ignore busy_remaining: got %0d want 7", n);
        end
        checks++;
        if (HI !== 32'd2 || LO !== 32'd14) begin
            failures++;
            $display("FAIL ignore result: got %h/%h want 00000002/0000000e", HI, LO);
        end
    endtask

    task automatic test_reset_in_flight();
        int seen_busy;
        issue(OP_MTHI, 32'hAAAA5555, 32'd0);
        issue(OP_MTLO, 32'h5555AAAA, 32'd0);
        issue(OP_DIVU, 32'd100, 32'd7);
        step();
        step();
        start = 1'b1;
        op    = OP_MTLO;
        A     = 32'd5;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || LO !== 32'h5555AAAA) begin
            failures++;
            $display("FAIL midrun mtlo: busy=%b LO=%h want 1/5555aaaa", busy, LO);
        end
        step();
        step();
        // Busy cycle 6: reset overrides the operation.
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL reset_in_flight: busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
        end
        seen_busy = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (busy) seen_busy++;
        end
        checks++;
        if (seen_busy !== 0 || HI !== 32'd0 || LO !== 32'd0) begin
            failures++;
            $display("FAIL post_reset: busy_cycles=%0d HI=%h LO=%h want 0/0/0", seen_busy, HI, LO);
        end
    endtask

    task automatic test_madd();
        int n;
        issue(OP_MTLO, 32'd10, 32'd0);
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MADD, 32'd3, 32'd4);
`ifdef XALU_MADD_EN
        wait_idle(n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL madd busy_cycles: got %0d want 5", n);
        end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd22) begin
            failures++;
            $display("FAIL madd result: got %h/%h want 00000000/00000016", HI, LO);
        end
`else
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) n++;
            step();
        end
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL madd_disabled busy_cycles: got %0d want 0", n);
        end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd10) begin
            failures++;
            $display("FAIL madd_disabled result: got %h/%h want 00000000/0000000a", HI, LO);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_arith();
        test_divzero();
        test_ignore_start();
        test_reset_in_flight();
        test_madd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xalu_muldiv.md
Name: xalu_muldiv

Overview:
- Multiply/divide unit (XALU) in the E stage of the 5-stage MIPS pipeline.
- Owns the HI and LO registers and drives them to the E-stage result select, which picks ALU, HI or LO output.
- Executes mult/multu/div/divu with fixed multi-cycle latency, and mthi/mtlo in a single cycle.
- Exports busy so the hazard unit can stall D-stage instructions that use HI/LO.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (and madd/maddu when enabled); legal range 1..15.
- DIV_CYCLES, 10, cycles busy stays high for div/divu; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  qualifies op/A/B as a valid XALU request this cycle.
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
- A  input  32  forwarded rs operand (DE_RD1 after forwarding).
- B  input  32  forwarded rt operand (DE_RD2 after forwarding).
- busy  output  1  high while a multi-cycle operation is in flight.
- HI  output  32  HI register, driven directly from the flop.
- LO  output  32  LO register, driven directly from the flop.

Behaviour:
- Reset: at the rising edge with reset=1, HI=0, LO=0, busy=0, cycle counter=0, latched operands=0.
- Reset overrides any in-flight operation and any coincident start; HI/LO are not updated.
- State machine has two states: IDLE (busy=0) and RUN (busy=1).
- Counter: 4-bit down-counter.
- IDLE, start=1, op 0-3 (or 6-7 when enabled):
  - latch A, B and op;
  - set counter to MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
  - busy is high from the following cycle.
- IDLE, start=1, op 4 (mthi): HI<=A at this edge; LO unchanged; busy stays 0.
- IDLE, start=1, op 5 (mtlo): LO<=A at this edge; HI unchanged; busy stays 0.
- RUN: the counter decrements each edge.
  - At the edge where counter==1, write the result to HI/LO, clear busy and return to IDLE.
  - busy is therefore high for exactly N cycles.
  - The new HI/LO values are visible in the first cycle where busy=0.
- start=1 while in RUN: ignored entirely; no relatch, counter unaffected, mthi/mtlo not applied. The hazard unit guarantees this never happens; the bench checks that it is ignored.
- Arithmetic is computed from the latched operands only. Changing A/B during RUN has no effect.
- mult: signed 64-bit product {HI,LO} = $signed(A)*$signed(B).
- multu: unsigned 64-bit product {HI,LO} = A*B.
- div: LO = signed quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = A/B, HI = A%B, both unsigned.
- Divide by zero (latched B==0): full busy latency still applies; HI and LO keep their previous values.
- Result select for the downstream mux: HI/LO are plain register outputs with no bypass. A new value appears the cycle after its write edge.

Optional Feature:
- Macro: XALU_MADD_EN.
- Defined:
  - op 6 (madd): {HI,LO} <= {HI,LO} + $signed(A)*$signed(B), wrapping mod 2^64.
  - op 7 (maddu): the same sum using the unsigned product.
  - Both take MULT_CYCLES.
  - The accumulate uses HI/LO as they are at the completion edge.
- Not defined:
  - op 6/7 with start=1 is a no-op: no busy, HI/LO unchanged.
  - The accumulate datapath is not synthesised.

Test Plan:
- Reset, then start mult with A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div with A=0xFFFFFFF9 (-7), B=2 -> busy high for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero:
  - mthi A=0x12345678 -> HI=0x12345678 next cycle, busy=0;
  - mtlo A=0x9ABCDEF0 -> LO=0x9ABCDEF0, busy=0;
  - divu with B=0 -> busy high for 10 cycles, then HI/LO remain 0x12345678/0x9ABCDEF0.
- Start divu with A=100, B=7:
  - pulse start with mtlo A=5 at busy cycle 3 -> ignored;
  - assert reset at busy cycle 6 -> busy=0, HI=LO=0, and no later write.
- With XALU_MADD_EN defined:
  - mtlo 10, mthi 0, then madd A=3, B=4 -> after 5 cycles HI=0, LO=22.
- Without XALU_MADD_EN:
  - the same madd request leaves HI=0, LO=10 with busy never asserted.
